// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the decode stage.
// The immediate (and its illegal-format flag) is expanded combinationally
// from Instr[31:7] and ImmSrc as the request is accepted. It is then stored in
// a two-entry skid buffer, so that in_ready is driven from a register and never
// depends combinationally on out_ready.
module imm_gen_pipe #(
    parameter int W     = 32,  // XLEN, 32 or 64
    parameter int DEPTH = 2    // skid-buffer entries, fixed at 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   ImmSrc,
    input  logic [24:0]  Instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_err
);

    // The value of each state is the number of occupied entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam logic [1:0] FULL_L = 2'(DEPTH);

    occ_e         state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic         head_err_q, head_err_d;
    logic [W-1:0] tail_q, tail_d;
    logic         tail_err_q, tail_err_d;

    logic [W-1:0] imm_new;
    logic         err_new;
    logic         accept;
    logic         pop;

    // Expand one immediate. The 32-bit form is built first and then extended
    // to W, so that U-type sign-extends above bit 31 when W is 64.
    function automatic logic [W:0] expand_imm(input logic [2:0] sel,
                                              input logic [24:0] raw);
        logic [31:0]        ins;
        logic signed [31:0] s32;
        logic [5:0]         sh;
        logic [W-1:0]       val;
        logic               err;
        ins = {raw, 7'b0};
        s32 = '0;
        val = '0;
        err = 1'b0;
        sh  = (W == 64) ? ins[25:20] : {1'b0, ins[24:20]};
        case (sel)
            3'b000: begin
                s32 = {{20{ins[31]}}, ins[31:20]};
                val = W'(s32);
            end
            3'b001: begin
                s32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                val = W'(s32);
            end
            3'b010: begin
                s32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                val = W'(s32);
            end
            3'b011: begin
                s32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                val = W'(s32);
            end
            3'b100: begin
                s32 = {ins[31:12], 12'b0};
                val = W'(s32);
            end
            3'b101:  val = W'(ins[19:15]);
            3'b110:  val = W'(sh);
            default: begin
                val = '0;
                err = 1'b1;
            end
        endcase
        return {err, val};
    endfunction

    assign {err_new, imm_new} = expand_imm(ImmSrc, Instr);

    assign in_ready  = (state_q < FULL_L);
    assign out_valid = (state_q != EMPTY);
    assign out       = head_q;
    assign out_err   = head_err_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next occupancy and entry contents. The head is only replaced once it has been popped.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        head_err_d = head_err_q;
        tail_d     = tail_q;
        tail_err_d = tail_err_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        head_d     = imm_new;
                        head_err_d = err_new;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d     = imm_new;
                        head_err_d = err_new;
                    end else if (accept) begin
                        state_d    = TWO;
                        tail_d     = imm_new;
                        tail_err_d = err_new;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d    = ONE;
                        head_d     = tail_q;
                        head_err_d = tail_err_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Occupancy and entry registers. Reset clears both entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            head_err_q <= 1'b0;
            tail_q     <= '0;
            tail_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            head_err_q <= head_err_d;
            tail_q     <= tail_d;
            tail_err_q <= tail_err_d;
        end
    end

endmodule
